instr_fetch_unit: RTL and testbench

Multicycle instruction fetch front-end that produces the instruction stream consumed by `control_unit`. It holds the PC, issues one request at a time to instruction memory and presents each fetched word, its PC and its 7-bit opcode to decode over a valid/ready handshake. It also applies taken-branch redirects, discarding any fetch already in flight.

---
 rtl/instr_fetch_unit.sv | 149 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Multicycle instruction fetch front-end: holds the PC, issues one request at a time to
// instruction memory and hands each fetched word to decode over a valid/ready handshake.
// Taken-branch redirects retarget the PC and discard any fetch already in flight.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect target halts fetch).
module instr_fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [6:0]      opcode,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            misalign_err
);

    typedef enum logic [2:0] {StIdle, StReq, StWait, StHold, StHalt} state_e;

    localparam logic [XLEN-1:0] Nop = XLEN'(32'h0000_0013);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic            drop_q, drop_d;
    logic            err_q, err_d;
    logic [XLEN-1:0] target;
    logic            misaligned;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign target     = redirect_pc;
    assign misaligned = redirect & (redirect_pc[1:0] != 2'b00);
`else
    // Without the trap the low bits are simply ignored.
    assign target     = redirect_pc & ~XLEN'(3);
    assign misaligned = 1'b0;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pc_q      <= RESET_PC;
            inst_q    <= Nop;
            inst_pc_q <= RESET_PC;
            drop_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            drop_q    <= drop_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic; a redirect takes priority over every other event in its cycle.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        drop_d    = drop_q;
        err_d     = err_q;
        if (state_q != StHalt && misaligned) begin
            // Offending target is still loaded so imem_addr exposes it.
            pc_d    = target;
            err_d   = 1'b1;
            drop_d  = 1'b0;
            state_d = StHalt;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (redirect) pc_d = target;
                    state_d = StReq;
                end
                StReq: begin
                    if (redirect) begin
                        pc_d = target;
                        if (imem_req_ready) begin
                            // Request went out with the old PC; its response is stale.
                            drop_d  = 1'b1;
                            state_d = StWait;
                        end
                    end else if (imem_req_ready) begin
                        state_d = StWait;
                    end
                end
                StWait: begin
                    if (redirect) begin
                        pc_d = target;
                        if (imem_rsp_valid) begin
                            drop_d  = 1'b0;
                            state_d = StReq;
                        end else begin
                            drop_d = 1'b1;
                        end
                    end else if (imem_rsp_valid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = StReq;
                        end else begin
                            inst_d    = imem_rsp_data;
                            inst_pc_d = pc_q;
                            pc_d      = pc_q + XLEN'(4);
                            state_d   = StHold;
                        end
                    end
                end
                StHold: begin
                    if (redirect) begin
                        pc_d    = target;
                        state_d = StReq;
                    end else if (inst_ready) begin
                        state_d = StReq;
                    end
                end
                StHalt: begin
                    state_d = StHalt;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Outputs come from registers or the state decode only.
    always_comb begin
        imem_req_valid = (state_q == StReq);
        inst_valid     = (state_q == StHold);
        imem_addr      = pc_q;
        inst           = inst_q;
        inst_pc        = inst_pc_q;
        opcode         = inst_q[6:0];
        misalign_err   = err_q;
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized traffic,
// compared every cycle against a transaction-level model of the fetch stream.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [6:0]  opcode;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        misalign_err;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    // Model: where fetch will go, whether a fetch is in flight (and stale), what decode holds.
    logic [31:0] m_pc, m_inst, m_ipc;
    bit          m_started, m_halted, m_err, m_out, m_stale, m_held;

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .opcode         (opcode),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .misalign_err   (misalign_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic void model_reset();
        m_pc = 32'h0; m_inst = 32'h0000_0013; m_ipc = 32'h0;
        m_started = 0; m_halted = 0; m_err = 0; m_out = 0; m_stale = 0; m_held = 0;
    endfunction

    // Advance the model by one clock edge given the inputs sampled at that edge.
    function automatic void model_step(input bit rq, input bit rs, input logic [31:0] d,
                                       input bit ir, input bit rd, input logic [31:0] rp);
        logic [31:0] tgt;
        bit          bad;
`ifdef FETCH_MISALIGN_TRAP_EN
        tgt = rp;
        bad = rd && (rp % 4 != 0);
`else
        tgt = rp - (rp % 4);
        bad = 0;
`endif
        if (m_halted) return;
        if (bad) begin
            m_pc = tgt; m_err = 1; m_halted = 1; m_held = 0; m_out = 0;
            return;
        end
        if (!m_started) begin
            if (rd) m_pc = tgt;
            m_started = 1;
        end else if (m_held) begin
            if (rd) begin m_pc = tgt; m_held = 0; end
            else if (ir) m_held = 0;
        end else if (m_out) begin
            if (rd) begin
                m_pc = tgt;
                if (rs) begin m_out = 0; m_stale = 0; end
                else m_stale = 1;
            end else if (rs) begin
                m_out = 0;
                if (m_stale) m_stale = 0;
                else begin m_held = 1; m_inst = d; m_ipc = m_pc; m_pc = m_pc + 32'd4; end
            end
        end else begin
            if (rd) m_pc = tgt;
            if (rq) begin m_out = 1; m_stale = rd; end
        end
    endfunction

    // Drive one cycle of inputs, step the model at the edge, return 1 time unit later.
    task automatic cycle(input bit rq, input bit rs, input logic [31:0] d, input bit ir,
                         input bit rd, input logic [31:0] rp);
        imem_req_ready = rq; imem_rsp_valid = rs; imem_rsp_data = d;
        inst_ready = ir; redirect = rd; redirect_pc = rp;
        @(posedge clk);
        model_step(rq, rs, d, ir, rd, rp);
        #1;
        imem_req_ready = 0; imem_rsp_valid = 0; inst_ready = 0; redirect = 0;
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("req_valid", {31'b0, imem_req_valid},
                {31'b0, m_started && !m_halted && !m_out && !m_held});
            chk("imem_addr", imem_addr, m_pc);
            chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_held});
            chk("inst", inst, m_inst);
            chk("inst_pc", inst_pc, m_ipc);
            chk("opcode", {25'b0, opcode}, {25'b0, m_inst[6:0]});
            chk("misalign_err", {31'b0, misalign_err}, {31'b0, m_err});
        end
    end

    initial begin
        logic [31:0] rp;
        model_reset();
        cmp_en = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst req_valid", {31'b0, imem_req_valid}, 32'h0);
        chk("rst inst", inst, 32'h0000_0013);
        chk("rst inst_pc", inst_pc, 32'h0);
        rst_n = 1;

        // Zero-wait fetch stream: addresses 0, 4, 8, 12.
        cycle(0, 0, 0, 0, 0, 0);
        chk("first req", {31'b0, imem_req_valid}, 32'h1);
        chk("addr0", imem_addr, 32'h0);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 32'h0000_0033, 0, 0, 0);
        chk("hold0 valid", {31'b0, inst_valid}, 32'h1);
        chk("hold0 pc", inst_pc, 32'h0);
        chk("opcode0", {25'b0, opcode}, {25'b0, 7'b0110011});
        cycle(0, 0, 0, 1, 0, 0);
        chk("addr4", imem_addr, 32'h4);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 32'h0000_2003, 0, 0, 0);
        chk("opcode1", {25'b0, opcode}, {25'b0, 7'b0000011});
        chk("hold1 pc", inst_pc, 32'h4);
        cycle(0, 0, 0, 1, 0, 0);
        chk("addr8", imem_addr, 32'h8);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 32'h0000_0013, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        chk("addr12", imem_addr, 32'hC);

        // Slow memory (3 cycles) and stalled decode (5 cycles).
        cycle(1, 0, 0, 0, 0, 0);
        repeat (3) cycle(0, 0, 0, 0, 0, 0);
        chk("wait no req", {31'b0, imem_req_valid}, 32'h0);
        cycle(0, 1, 32'hABCD_E0B3, 0, 0, 0);
        repeat (5) cycle(0, 0, 0, 0, 0, 0);
        chk("stall inst", inst, 32'hABCD_E0B3);
        chk("stall pc", inst_pc, 32'hC);
        chk("stall no req", {31'b0, imem_req_valid}, 32'h0);
        cycle(0, 0, 0, 1, 0, 0);
        chk("addr16", imem_addr, 32'h10);

        // Redirect in WAIT, response one cycle later is dropped.
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 32'h100);
        cycle(0, 1, 32'h1111_1111, 0, 0, 0);
        chk("drop no valid", {31'b0, inst_valid}, 32'h0);
        chk("redir addr", imem_addr, 32'h100);

        // Redirect coincident with the response in WAIT.
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 32'h2222_2222, 0, 1, 32'h40);
        chk("coinc addr", imem_addr, 32'h40);
        chk("coinc no valid", {31'b0, inst_valid}, 32'h0);
        // Redirect in HOLD with decode stalled.
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 32'h3333_3333, 0, 0, 0);
        chk("hold40 pc", inst_pc, 32'h40);
        cycle(0, 0, 0, 0, 1, 32'h40);
        chk("hold redir addr", imem_addr, 32'h40);
        chk("hold redir valid", {31'b0, inst_valid}, 32'h0);

        // PC wrap at the top of the address space.
        cycle(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 32'h0000_0073, 0, 0, 0);
        chk("wrap inst_pc", inst_pc, 32'hFFFF_FFFC);
        cycle(0, 0, 0, 1, 0, 0);
        chk("wrap addr", imem_addr, 32'h0);

        // Randomized traffic, including stray responses outside WAIT.
        for (int i = 0; i < 3000; i++) begin
            rp = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
            rp = rp & 32'hFFFF_FFFC;
`endif
            cycle($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0, rp);
        end

        // Misaligned redirect target.
        cycle(0, 0, 0, 0, 1, 32'h102);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("misalign err", {31'b0, misalign_err}, 32'h1);
        chk("misalign addr", imem_addr, 32'h102);
        repeat (4) cycle(1, 1, 32'h5, 1, 1, 32'h200);
        chk("halt no req", {31'b0, imem_req_valid}, 32'h0);
        chk("halt addr", imem_addr, 32'h102);
`else
        chk("align addr", imem_addr, 32'h100);
        chk("align err", {31'b0, misalign_err}, 32'h0);
        for (int k = 0; k < 5 && !imem_req_valid; k++) cycle(0, 1, 32'h5, 1, 0, 0);
        chk("align req", {31'b0, imem_req_valid}, 32'h1);
        chk("align req addr", imem_addr, 32'h100);
`endif

        // Reset mid-operation, then a stray response right after release.
        repeat (7) cycle($urandom_range(0, 1) == 1, 0, 0, 0, 0, 0);
        rst_n = 0;
        model_reset();
        #1;
        chk("mid rst err", {31'b0, misalign_err}, 32'h0);
        chk("mid rst valid", {31'b0, inst_valid}, 32'h0);
        chk("mid rst inst", inst, 32'h0000_0013);
        @(posedge clk);
        #1;
        rst_n = 1;
        cycle(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
        cycle(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
        chk("post rst req", {31'b0, imem_req_valid}, 32'h1);
        chk("post rst valid", {31'b0, inst_valid}, 32'h0);
        repeat (200) cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom,
                           $urandom_range(0, 1) == 1, 0, 0);

        @(posedge clk);
        cmp_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
